// File: rtl/stereo_centroid_pair.sv
// rtl/stereo_centroid_pair.sv - per-frame x-centroid pair for cam1/cam2 feeding the stereo depth stage
//
// Accumulates sum/count of masked pixel columns per camera, snapshots them on
// frame_done, then divides both with one shared restoring divider (DIV1 = cam1,
// DIV2 = cam2) and strobes a registered (x_1, x_2) pair.
// found_out is set only when both counts reach MIN_PIXELS and x_1 > x_2.
//
// Optional build macro: CENTROID_ROUND_EN (round-half-up centroids; default floor).
//
// Ports:
//   clk_in, rst_n_in                 clock, synchronous active-low reset
//   camN_valid_in / camN_mask_in     pixel strobe / pixel belongs to marker
//   camN_x_in [X_W]                  pixel column
//   camN_frame_done_in               single-cycle end-of-frame pulse
//   x_1_out, x_2_out [X_W]           cam1 / cam2 centroids (held between strobes)
//   found_out                        pair usable (x_1_out - x_2_out >= 1)
//   pair_valid_out                   single-cycle result strobe
//   busy_out                         divider active
//   drop_out                         single-cycle pulse: unconsumed snapshot overwritten
module stereo_centroid_pair #(
  parameter int X_W        = 12,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           cam1_valid_in,
  input  logic           cam1_mask_in,
  input  logic [X_W-1:0] cam1_x_in,
  input  logic           cam1_frame_done_in,
  input  logic           cam2_valid_in,
  input  logic           cam2_mask_in,
  input  logic [X_W-1:0] cam2_x_in,
  input  logic           cam2_frame_done_in,
  output logic [X_W-1:0] x_1_out,
  output logic [X_W-1:0] x_2_out,
  output logic           found_out,
  output logic           pair_valid_out,
  output logic           busy_out,
  output logic           drop_out
);

  localparam int SUM_W  = X_W + CNT_W;
  localparam int STEP_W = $clog2(SUM_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIV1, DIV2, OUT} state_t;

  state_t state_q, state_d;

  // index 0 = cam1, index 1 = cam2
  logic [1:0]       hit, fd, inc;
  logic [X_W-1:0]   px [2];
  logic [SUM_W-1:0] sum_q [2], sum_nx [2], snap_sum_q [2], dvd [2];
  logic [CNT_W-1:0] cnt_q [2], cnt_nx [2], snap_cnt_q [2];
  logic [1:0]       pend_q;

  // shared divider and working copies of the pair being processed
  logic [SUM_W-1:0]  dq_q;      // dividend shifting out, quotient shifting in
  logic [CNT_W-1:0]  rem_q, dvs_q;
  logic [SUM_W-1:0]  d2_q;      // cam2 dividend, waits through DIV1
  logic [CNT_W-1:0]  c1_q, c2_q;
  logic [X_W-1:0]    q1_q;
  logic [STEP_W-1:0] step_q;

  logic [X_W-1:0] x1_q, x2_q;
  logic           found_q, pv_q, drop_q;

  logic             take, last_step, found;
  logic [CNT_W:0]   trial;
  logic             ge;
  logic [CNT_W-1:0] rem_step;
  logic [SUM_W-1:0] dq_step;

  assign hit   = {cam2_valid_in & cam2_mask_in, cam1_valid_in & cam1_mask_in};
  assign fd    = {cam2_frame_done_in, cam1_frame_done_in};
  assign px[0] = cam1_x_in;
  assign px[1] = cam2_x_in;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // once the count saturates, the sum freezes too so the ratio stays sane
      inc[i]    = hit[i] & (cnt_q[i] != CNT_MAX);
      sum_nx[i] = sum_q[i] + (inc[i] ? SUM_W'(px[i]) : {SUM_W{1'b0}});
      cnt_nx[i] = cnt_q[i] + CNT_W'(inc[i]);
`ifdef CENTROID_ROUND_EN
      dvd[i]    = snap_sum_q[i] + SUM_W'(snap_cnt_q[i] >> 1);
`else
      dvd[i]    = snap_sum_q[i];
`endif
    end
  end

  // OUT may launch the next pair directly so back-to-back pairs lose no cycle
  assign take      = ((state_q == IDLE) || (state_q == OUT)) && (pend_q == 2'b11);
  assign last_step = (step_q == LAST_STEP);

  // one restoring-division step: remainder stays below the divisor, so CNT_W+1 bits suffice
  assign trial    = {rem_q, dq_q[SUM_W-1]};
  assign ge       = (trial >= {1'b0, dvs_q});
  assign rem_step = ge ? CNT_W'(trial - {1'b0, dvs_q}) : trial[CNT_W-1:0];
  assign dq_step  = {dq_q[SUM_W-2:0], ge};

  // cnt >= MIN_CNT also rules out the divide-by-zero quotient
  assign found = (c1_q >= MIN_CNT) && (c2_q >= MIN_CNT) && (q1_q > dq_q[X_W-1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = DIV1;
      DIV1:    if (last_step) state_d = DIV2;
      DIV2:    if (last_step) state_d = OUT;
      OUT:     state_d = take ? DIV1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      for (int i = 0; i < 2; i++) begin
        sum_q[i]      <= '0;
        cnt_q[i]      <= '0;
        snap_sum_q[i] <= '0;
        snap_cnt_q[i] <= '0;
      end
      pend_q  <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      d2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      q1_q    <= '0;
      step_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      found_q <= 1'b0;
      pv_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= (state_q == OUT);
      // a snapshot consumed by take on this edge is not a drop
      drop_q  <= (|(fd & pend_q)) & ~take;
      pend_q  <= fd | (pend_q & ~{2{take}});

      for (int i = 0; i < 2; i++) begin
        if (fd[i]) begin
          snap_sum_q[i] <= sum_nx[i];
          snap_cnt_q[i] <= cnt_nx[i];
          sum_q[i]      <= '0;
          cnt_q[i]      <= '0;
        end else begin
          sum_q[i] <= sum_nx[i];
          cnt_q[i] <= cnt_nx[i];
        end
      end

      if (state_q == OUT) begin
        found_q <= found;
        if (found) begin
          x1_q <= q1_q;
          x2_q <= dq_q[X_W-1:0];
        end
      end

      if (take) begin
        dq_q   <= dvd[0];
        rem_q  <= '0;
        dvs_q  <= snap_cnt_q[0];
        d2_q   <= dvd[1];
        c1_q   <= snap_cnt_q[0];
        c2_q   <= snap_cnt_q[1];
        step_q <= '0;
      end else if ((state_q == DIV1) || (state_q == DIV2)) begin
        dq_q   <= dq_step;
        rem_q  <= rem_step;
        step_q <= step_q + STEP_W'(1);
        if (last_step) begin
          step_q <= '0;
          if (state_q == DIV1) begin
            q1_q  <= dq_step[X_W-1:0];
            dq_q  <= d2_q;
            rem_q <= '0;
            dvs_q <= c2_q;
          end
        end
      end
    end
  end

  assign x_1_out        = x1_q;
  assign x_2_out        = x2_q;
  assign found_out      = found_q;
  assign pair_valid_out = pv_q;
  assign busy_out       = (state_q == DIV1) || (state_q == DIV2);
  assign drop_out       = drop_q;

endmodule

// File: tb/tb_stereo_centroid_pair.sv
// tb/tb_stereo_centroid_pair.sv - directed bench for stereo_centroid_pair
module tb_stereo_centroid_pair;

  localparam int X_W = 12;
`ifdef CENTROID_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  // strobe lands 65 edges after the take edge, which is one edge after frame_done
  localparam int LAT = 66;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           c1v, c1m, c1f, c2v, c2m, c2f;
  logic [X_W-1:0] c1x, c2x;
  logic [X_W-1:0] x1, x2;
  logic           found, pv, busy, drop;

  always #5 clk = ~clk;

  stereo_centroid_pair dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .cam1_valid_in      (c1v),
    .cam1_mask_in       (c1m),
    .cam1_x_in          (c1x),
    .cam1_frame_done_in (c1f),
    .cam2_valid_in      (c2v),
    .cam2_mask_in       (c2m),
    .cam2_x_in          (c2x),
    .cam2_frame_done_in (c2f),
    .x_1_out            (x1),
    .x_2_out            (x2),
    .found_out          (found),
    .pair_valid_out     (pv),
    .busy_out           (busy),
    .drop_out           (drop)
  );

  typedef struct {
    int b1; int n1; int b2; int n2;
    bit found;
    int x1f; int x2f; int x1r; int x2r;
  } vec_t;

  vec_t tbl [9];
  int   n_vec = 0;
  int   n_bad = 0;
  int   drop_cnt = 0;

  always @(negedge clk) if (drop) drop_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c1v = 0; c1m = 0; c1x = '0; c1f = 0;
    c2v = 0; c2m = 0; c2x = '0; c2f = 0;
  endtask

  // one valid-but-unmasked pixel, then masked runs; frame_done either with the
  // last pixel or on the following cycle, on the cameras selected by fdm
  task automatic stream(input int b1, input int n1, input int b2, input int n2,
                        input bit fd_last, input bit [1:0] fdm);
    int m;
    m = (n1 > n2) ? n1 : n2;
    c1v = 1; c1m = 0; c1x = '1; c2v = 1; c2m = 0; c2x = '1;
    @(posedge clk); #1;
    for (int i = 0; i < m; i++) begin
      c1v = (i < n1); c1m = 1; c1x = X_W'(b1 + i);
      c2v = (i < n2); c2m = 1; c2x = X_W'(b2 + i);
      if (fd_last && i == m - 1) begin c1f = fdm[0]; c2f = fdm[1]; end
      @(posedge clk); #1;
    end
    idle_inputs();
    if (!fd_last) begin
      c1f = fdm[0]; c2f = fdm[1];
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic wait_strobe(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (pv) begin lat = n; break; end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input bit f,
                              input int ex1, input int ex2);
    check({tag, " latency"}, lat, LAT);
    check({tag, " found"}, found, f);
    check({tag, " x_1"}, x1, ex1);
    check({tag, " x_2"}, x2, ex2);
    @(posedge clk); #1;
    check({tag, " strobe width"}, pv, 0);
  endtask

  initial begin
    int lat, first, second, pvcnt;
    //          b1    n1  b2   n2  found x1f   x2f  x1r   x2r
    tbl[0] = '{600,  20, 500, 20, 1'b1, 609,  509, 610,  510};
    tbl[1] = '{600,  20, 500, 10, 1'b0, 609,  509, 610,  510};
    tbl[2] = '{300,  20, 300, 20, 1'b0, 609,  509, 610,  510};
    tbl[3] = '{100,  20, 200, 20, 1'b0, 609,  509, 610,  510};
    tbl[4] = '{1000, 20, 0,   20, 1'b1, 1009, 9,   1010, 10};
    tbl[5] = '{601,  20, 600, 20, 1'b1, 610,  609, 611,  610};
    tbl[6] = '{800,  16, 700, 16, 1'b1, 807,  707, 808,  708};
    tbl[7] = '{800,  15, 700, 16, 1'b0, 807,  707, 808,  708};
    tbl[8] = '{0,    0,  500, 20, 1'b0, 807,  707, 808,  708};

    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset x_1", x1, 0);
    check("reset x_2", x2, 0);
    check("reset found", found, 0);
    check("reset pair_valid", pv, 0);
    check("reset busy", busy, 0);
    check("reset drop", drop, 0);
    rst_n = 1;
    @(posedge clk); #1;

    drop_cnt = 0;
    for (int v = 0; v < 9; v++) begin
      stream(tbl[v].b1, tbl[v].n1, tbl[v].b2, tbl[v].n2, 1'b0, 2'b11);
      wait_strobe(lat);
      check_result($sformatf("vec%0d", v), lat, tbl[v].found,
                   RND ? tbl[v].x1r : tbl[v].x1f, RND ? tbl[v].x2r : tbl[v].x2f);
    end
    check("table drops", drop_cnt, 0);

    // cam1 ends two frames before cam2 ends one: newest cam1 snapshot wins
    drop_cnt = 0;
    stream(600, 20, 0, 0, 1'b0, 2'b01);
    stream(700, 20, 0, 0, 1'b0, 2'b01);
    stream(0, 0, 500, 20, 1'b0, 2'b10);
    wait_strobe(lat);
    check_result("overrun", lat, 1'b1, RND ? 710 : 709, RND ? 510 : 509);
    check("overrun drops", drop_cnt, 1);

    // 16th pixel shares the frame_done cycle: only counted in the ending frame
    stream(800, 16, 700, 16, 1'b1, 2'b11);
    wait_strobe(lat);
    check_result("same-cycle px", lat, 1'b1, RND ? 808 : 807, RND ? 708 : 707);
    stream(600, 20, 500, 20, 1'b0, 2'b11);
    wait_strobe(lat);
    check_result("no carry-over", lat, 1'b1, RND ? 610 : 609, RND ? 510 : 509);

    // next pair accumulates during division and ends in DIV2
    stream(600, 20, 500, 20, 1'b0, 2'b11);
    first = -1; second = -1;
    for (int n = 1; n <= 300; n++) begin
      c1v = (n <= 20); c1m = 1; c1x = X_W'(1000 + n - 1);
      c2v = (n <= 20); c2m = 1; c2x = X_W'(n - 1);
      c1f = (n == 45); c2f = (n == 45);
      @(posedge clk); #1;
      idle_inputs();
      if (n == 45) check("busy in div2", busy, 1);
      if (pv) begin
        if (first < 0) begin
          first = n;
          check("b2b first found", found, 1);
          check("b2b first x_1", x1, RND ? 610 : 609);
          check("b2b first x_2", x2, RND ? 510 : 509);
        end else begin
          second = n;
          check("b2b second found", found, 1);
          check("b2b second x_1", x1, RND ? 1010 : 1009);
          check("b2b second x_2", x2, RND ? 10 : 9);
          break;
        end
      end
    end
    check("b2b first latency", first, LAT);
    check("b2b spacing", second - first, 65);

    // reset while in DIV1
    stream(600, 20, 500, 20, 1'b0, 2'b11);
    repeat (10) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("mid reset x_1", x1, 0);
    check("mid reset x_2", x2, 0);
    check("mid reset found", found, 0);
    check("mid reset pair_valid", pv, 0);
    check("mid reset busy", busy, 0);
    check("mid reset drop", drop, 0);
    pvcnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (pv) pvcnt++;
    end
    check("aborted strobe count", pvcnt, 0);
    stream(600, 20, 500, 20, 1'b0, 2'b11);
    wait_strobe(lat);
    check_result("after reset", lat, 1'b1, RND ? 610 : 609, RND ? 510 : 509);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
